// File: rtl/dbg_scan.sv
// Debug display scanner: steps an entry index across the selected debug source and
// latches a tagged word from it, paced by a free-running tick divider or a step button.
//
// state | meaning
// IDLE  | waiting for an advance event
// ADDR  | rd_addr stable at the sources, read data sampled into disp_data at the end
// CAPT  | disp_data/disp_vld presented, rd_addr moves to the next entry at the end
module dbg_scan #(
    parameter int XLEN     = 32,
    parameter int NCH      = 4,
    parameter int IDX_W    = 5,
    parameter int TAG_W    = 4,
    parameter int TICK_DIV = 1 << 25,
    localparam int CH_W    = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int DIV_W   = $clog2(TICK_DIV)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [CH_W-1:0]       ch_sel,
    input  logic [1:0]            mode,
    input  logic                  step_i,
    input  logic [NCH*IDX_W-1:0]  depth_i,
    input  logic [NCH*XLEN-1:0]   rd_data,
    input  logic [XLEN-1:0]       byp_data,
    output logic [IDX_W-1:0]      rd_addr,
    output logic [XLEN-1:0]       disp_data,
    output logic                  disp_vld,
    output logic                  tick_o
);

    localparam logic [1:0] MODE_AUTO = 2'b00;
    localparam logic [1:0] MODE_STEP = 2'b10;
    localparam logic [1:0] MODE_BYP  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_CAPT = 2'b10
    } state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              step_q;
    logic [CH_W-1:0]   chsel_q;
    logic [IDX_W-1:0]  rd_addr_q, rd_addr_d;
    logic [XLEN-1:0]   disp_data_q, disp_data_d;
    logic              disp_vld_q, disp_vld_d;

    logic              tick;
    logic              adv;
    logic              ch_chg;
    logic [IDX_W-1:0]  depth_sel;
    logic [XLEN-1:0]   data_sel;
    logic [IDX_W:0]    addr_nxt;
    logic              addr_wrap;
    logic [XLEN-1:0]   capt_word;

    assign tick  = (div_q == DIV_W'(TICK_DIV - 1));
    assign div_d = tick ? '0 : div_q + DIV_W'(1);

    assign adv = ((mode == MODE_AUTO) && tick) ||
                 ((mode == MODE_STEP) && step_i && !step_q);

    assign ch_chg = (ch_sel != chsel_q);

    // Unpopulated channel numbers read as depth 0, so they display all ones.
    always_comb begin
        depth_sel = '0;
        data_sel  = '0;
        for (int k = 0; k < NCH; k++) begin
            if (int'(ch_sel) == k) begin
                depth_sel = depth_i[k*IDX_W +: IDX_W];
                data_sel  = rd_data[k*XLEN +: XLEN];
            end
        end
    end

    // Wrap covers the last entry, a depth of zero and an index left beyond a shrunken depth.
    assign addr_nxt  = {1'b0, rd_addr_q} + (IDX_W + 1)'(1);
    assign addr_wrap = (addr_nxt >= {1'b0, depth_sel});

    assign capt_word = (depth_sel == '0) ? '1
                     : {rd_addr_q[TAG_W-1:0], data_sel[XLEN-TAG_W-1:0]};

    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        disp_data_d = disp_data_q;
        disp_vld_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (adv) begin
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                state_d     = ST_CAPT;
                disp_data_d = capt_word;
                disp_vld_d  = 1'b1;
            end
            ST_CAPT: begin
                state_d   = ST_IDLE;
                rd_addr_d = addr_wrap ? '0 : addr_nxt[IDX_W-1:0];
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (mode == MODE_BYP) begin
            state_d     = ST_IDLE;
            rd_addr_d   = rd_addr_q;
            disp_data_d = byp_data;
            disp_vld_d  = 1'b0;
        end

        // A channel switch restarts the scan; any capture in flight is dropped.
        if (ch_chg) begin
            state_d    = ST_IDLE;
            rd_addr_d  = '0;
            disp_vld_d = 1'b0;
            if (mode != MODE_BYP) begin
                disp_data_d = disp_data_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            div_q       <= '0;
            step_q      <= 1'b0;
            chsel_q     <= '0;
            rd_addr_q   <= '0;
            disp_data_q <= '0;
            disp_vld_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            step_q      <= step_i;
            chsel_q     <= ch_sel;
            rd_addr_q   <= rd_addr_d;
            disp_data_q <= disp_data_d;
            disp_vld_q  <= disp_vld_d;
        end
    end

    assign rd_addr   = rd_addr_q;
    assign disp_data = disp_data_q;
    assign disp_vld  = disp_vld_q;
    assign tick_o    = tick;

endmodule
